// File: rtl/dispatcher_pkg.sv
// Shared types and sizing helpers for the multi-outstanding dispatcher.
// Default configuration constants are the top-level parameter defaults.
// Ports: none (package only).
package dispatcher_pkg;

  localparam int DEF_NUMBER_OF_QUEUES = 4;
  localparam int DEF_MAX_OUTSTANDING  = 4;
  localparam int DEF_LEVEL_SIZE       = 5;
  localparam int DEF_REGISTER_SIZE    = 32;

  // Width of a counter that must represent 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int ID_W     = $clog2(DEF_NUMBER_OF_QUEUES);
  localparam int OUT_DEF_W = $clog2(DEF_MAX_OUTSTANDING + 1);

  typedef logic [ID_W-1:0]      queue_id_t;
  typedef logic [OUT_DEF_W-1:0] outstanding_t;

endpackage

// File: rtl/id_fifo.sv
// id_fifo: in-order circular buffer of granted queue ids.
// Latency: push visible at head one cycle later; head is combinational.
// Backpressure: push while full is accepted only together with a pop.
// Ports: clock, reset (async, high), push/push_data, pop, head, empty, count.
module id_fifo
  import dispatcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int CNT_W = count_width(DEPTH),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_outstanding_dispatcher.sv
// multi_outstanding_dispatcher: grants policy decisions to queues with up to
// MAX_OUTSTANDING transactions in flight; routes each consumed rising edge to
// the owner of the oldest in-flight transaction.
// Latency: grant 1 cycle (enable/id registered); update and hasBeenConsumed combinational.
// Backpressure: no grant while outstanding is at MAX_OUTSTANDING unless a retire frees a slot
// in the same cycle, or while the chosen queue has no un-granted occupancy.
// Ports: clock, reset (async, high); sel_valid/sel_id, levels, consumed, counter_reset in;
// enable, id, hasBeenConsumed, update, force_reset, outstanding, inflight_full,
// spurious_consume, stats out.
// Optional: DISPATCHER_STATS_EN enables per-queue saturating grant counters on stats.
module multi_outstanding_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = DEF_NUMBER_OF_QUEUES,
  parameter int MAX_OUTSTANDING  = DEF_MAX_OUTSTANDING,
  parameter int LEVEL_SIZE       = DEF_LEVEL_SIZE,
  parameter int REGISTER_SIZE    = DEF_REGISTER_SIZE,
  localparam int QID_W = $clog2(NUMBER_OF_QUEUES),
  localparam int OUT_W = count_width(MAX_OUTSTANDING)
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         sel_valid,
  input  logic [QID_W-1:0]                             sel_id,
  input  logic [NUMBER_OF_QUEUES-1:0][LEVEL_SIZE-1:0]  levels,
  input  logic                                         consumed,
  input  logic [REGISTER_SIZE-1:0]                     counter_reset,
  output logic                                         enable,
  output logic [QID_W-1:0]                             id,
  output logic [NUMBER_OF_QUEUES-1:0]                  hasBeenConsumed,
  output logic                                         update,
  output logic                                         force_reset,
  output logic [OUT_W-1:0]                             outstanding,
  output logic                                         inflight_full,
  output logic                                         spurious_consume,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] stats
);

  localparam int CMP_W = (LEVEL_SIZE > OUT_W) ? LEVEL_SIZE : OUT_W;
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  logic                                   consumed_ff;
  logic [REGISTER_SIZE-1:0]               counter_reset_ff;
  logic [NUMBER_OF_QUEUES-1:0][OUT_W-1:0] inflight;
  logic                                   fifo_empty;
  logic [QID_W-1:0]                       head;
  logic                                   retire;
  logic                                   retire_vld;
  logic                                   grant;
  logic                                   sel_in_range;
  logic [OUT_W-1:0]                       out_eff;
  logic [CMP_W-1:0]                       sel_level;
  logic [CMP_W-1:0]                       sel_inflight;

  assign retire     = consumed & ~consumed_ff;
  assign retire_vld = retire & ~fifo_empty;
  // A retire in this cycle frees its slot for a grant in the same cycle.
  assign out_eff    = outstanding - OUT_W'(retire_vld);
  assign sel_in_range = ({1'b0, sel_id} < (QID_W+1)'(NUMBER_OF_QUEUES));

  always_comb begin
    sel_level    = '0;
    sel_inflight = '0;
    if (sel_in_range) begin
      sel_level    = CMP_W'(levels[sel_id]);
      sel_inflight = CMP_W'(inflight[sel_id]);
    end
    // Only occupancy not already granted may be granted again.
    grant = ~reset & sel_valid & sel_in_range & (out_eff < MAX_OUT) & (sel_level > sel_inflight);
  end

  assign update        = grant;
  assign force_reset   = ~reset & (counter_reset != counter_reset_ff);
  assign inflight_full = (outstanding == MAX_OUT);

  always_comb begin
    hasBeenConsumed = '0;
    if (retire_vld) hasBeenConsumed[head] = 1'b1;
  end

  // The FIFO occupancy is the in-flight count.
  id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (QID_W)
  ) u_id_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (grant),
    .push_data (sel_id),
    .pop       (retire_vld),
    .head      (head),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable           <= 1'b0;
      id               <= '0;
      consumed_ff      <= 1'b1;
      counter_reset_ff <= '0;
      spurious_consume <= 1'b0;
    end else begin
      enable           <= grant;
      if (grant) id    <= sel_id;
      consumed_ff      <= consumed;
      counter_reset_ff <= counter_reset;
      if (retire && fifo_empty) spurious_consume <= 1'b1;
    end
  end

  // Grant and retire on the same queue cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
        if ((grant && sel_id == QID_W'(q)) && !(retire_vld && head == QID_W'(q)))
          inflight[q] <= inflight[q] + OUT_W'(1);
        else if (!(grant && sel_id == QID_W'(q)) && (retire_vld && head == QID_W'(q)))
          inflight[q] <= inflight[q] - OUT_W'(1);
      end
    end
  end

`ifdef DISPATCHER_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stats <= '0;
    end else begin
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
        if (force_reset)
          // A grant coinciding with the epoch change is the first of the new epoch.
          stats[q] <= (grant && sel_id == QID_W'(q)) ? REGISTER_SIZE'(1) : '0;
        else if (grant && sel_id == QID_W'(q) && stats[q] != {REGISTER_SIZE{1'b1}})
          stats[q] <= stats[q] + REGISTER_SIZE'(1);
      end
    end
  end
`else
  assign stats = '0;
`endif

endmodule

// File: doc/multi_outstanding_dispatcher.md
Name: multi_outstanding_dispatcher

Overview:
Successor to the single-transaction scheduler control path. It takes the already-muxed policy decision (queue id plus valid) and issues grants to the queues, allowing up to MAX_OUTSTANDING transactions in flight instead of one. Issued ids are tracked in order, and each `consumed` rising edge is routed back to the queue that owns the oldest in-flight transaction. It sits between the policy selector and the queue array, and it also drives the aging `update` and the policy `force_reset`.

Parameters:
- NUMBER_OF_QUEUES, 4, number of request queues (≥2).
- MAX_OUTSTANDING, 4, maximum in-flight grants (≥1; power of two not required).
- LEVEL_SIZE, 5, width of each queue occupancy input.
- REGISTER_SIZE, 32, width of `counter_reset` and of the statistics counters.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sel_valid  in  1  policy decision valid.
- sel_id  in  $clog2(NUMBER_OF_QUEUES)  queue chosen by the policy.
- levels  in  [NUMBER_OF_QUEUES][LEVEL_SIZE]  per-queue occupancy.
- consumed  in  1  level signal from the downstream port; each rising edge retires one transaction.
- counter_reset  in  REGISTER_SIZE  software epoch register.
- enable  out  1  one-cycle grant pulse.
- id  out  $clog2(NUMBER_OF_QUEUES)  queue granted; meaningful while `enable`=1, otherwise holds the last value.
- hasBeenConsumed  out  NUMBER_OF_QUEUES  one-hot retire pulse.
- update  out  1  combinational grant-decision strobe for the aging policy.
- force_reset  out  1  one-cycle pulse when `counter_reset` changes.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight count.
- inflight_full  out  1  `outstanding` == MAX_OUTSTANDING.
- spurious_consume  out  1  sticky error flag.
- stats  out  [NUMBER_OF_QUEUES][REGISTER_SIZE]  per-queue grant counters.

Behaviour:
- Reset values:
  - enable=0, id=0, outstanding=0, spurious_consume=0, all inflight counters 0, FIFO empty.
  - consumed_ff=1, so a `consumed` held high through reset is not counted.
  - counter_reset_ff=0, stats=0.
- Grant condition (combinational, cycle t): `sel_valid` & `outstanding` < MAX_OUTSTANDING & `levels[sel_id]` > `inflight[sel_id]`.
  - Comparison is unsigned; inflight is zero-extended to LEVEL_SIZE.
  - `update` equals the grant condition in cycle t.
- Grant effect at edge t→t+1:
  - `enable`=1 and `id`=`sel_id`.
  - `sel_id` is pushed into the in-order id FIFO; `inflight[sel_id]`++ and `outstanding`++.
  - Latency is 1 cycle. Back-to-back grants on consecutive cycles are legal.
- Retire: `retire` = `consumed` & ~`consumed_ff`.
  - If the FIFO is non-empty, `hasBeenConsumed[head]`=1 combinationally in the same cycle. On the edge, the FIFO pops, `inflight[head]`--, and `outstanding`--.
  - If the FIFO is empty, nothing is routed, `spurious_consume` is set and stays set until reset, and counters are unchanged.
- Grant and retire in the same cycle: both take effect.
  - `outstanding` is unchanged.
  - If the queue ids match, that queue's inflight counter is unchanged.
  - A grant is allowed at MAX_OUTSTANDING only if retire is also active in that cycle. The grant condition then uses `outstanding` − `retire`.
- `force_reset` = (`counter_reset` != `counter_reset_ff`). It does not disturb the FIFO or the inflight counters, because in-flight transactions must still retire.
- Counter widths: inflight counters are $clog2(MAX_OUTSTANDING+1) bits and never wrap, because both the grant and retire conditions guard them.
- Reset mid-operation: all in-flight state is discarded immediately (asynchronous). Any later `consumed` edge with no grant is flagged as spurious.

Optional Feature:
- Macro DISPATCHER_STATS_EN.
- Defined: `stats[q]` increments on every grant to q, saturates at all-ones, and clears on reset or `force_reset`. A grant in the same cycle as `force_reset` leaves the counter at 1.
- Undefined: `stats` is driven to constant 0 and no counter flops are inferred.

Decomposition:
- Package `dispatcher_pkg`:
  - `queue_id_t` (width $clog2(NUMBER_OF_QUEUES)).
  - `outstanding_t`.
  - Localparam ID_W.
- One sub-module, `id_fifo`:
  - Circular buffer of depth MAX_OUTSTANDING.
  - Simultaneous push/pop supported, including when full.
  - Asynchronous reset.
  - Exposes the head combinationally.

Test Plan:
1. Single grant: `levels[2]`=1, `sel_id`=2, `sel_valid`=1 → `enable` pulses at t+1 with `id`=2. No further grant to 2 until its retire. A `consumed` rise then gives `hasBeenConsumed`=4'b0100 and `outstanding` 1→0.
2. Saturation: MAX_OUTSTANDING=4, all `levels`=8, `sel_id` rotates 0,1,2,3,0 → exactly 4 grants and `inflight_full`=1. The 5th grant is issued in the cycle of the first `consumed` rise.
3. In-order routing: grants to queues 3,1,3 then three `consumed` edges → `hasBeenConsumed` = 1000, 0010, 1000 in that order.
4. Spurious and reset: `consumed` held at 1 across reset release → no retire. After a toggle with `outstanding`=0 → `spurious_consume`=1 and it stays set. Reset asserted mid-flight → all outputs return to reset values within the same cycle.
5. Epoch: `counter_reset` 0→5 → `force_reset` pulses for 1 cycle, `outstanding` is unchanged, and with DISPATCHER_STATS_EN defined `stats` clears. Saturation check: with REGISTER_SIZE=4, 20 grants to queue 0 → `stats[0]`=15.
